// File: rtl/softmax_ctrl_pkg.sv
// Shared types and constants for the softmax sequencer: FSM state encoding,
// element-count width and the default watchdog limit.
package softmax_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int CNT_W              = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/softmax_max_cmp.sv
// Combinational "a strictly greater than b" for the running-max search.
// ARITH_TYPE=1 compares signed integers; ARITH_TYPE=0 compares sign-magnitude floats.
module softmax_max_cmp #(
    parameter int ARITH_TYPE = 1,
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_gt
);

    localparam int MAG_W = E + M;

    generate
        if (ARITH_TYPE == 1) begin : g_fix
            assign o_gt = $signed(i_a) > $signed(i_b);
        end else begin : g_flt
            logic             w_a_neg;
            logic             w_b_neg;
            logic [MAG_W-1:0] w_a_mag;
            logic [MAG_W-1:0] w_b_mag;
            logic             w_both_zero;

            assign w_a_neg     = i_a[DATA_WIDTH-1];
            assign w_b_neg     = i_b[DATA_WIDTH-1];
            assign w_a_mag     = i_a[MAG_W-1:0];
            assign w_b_mag     = i_b[MAG_W-1:0];
            // +0 and -0 are equal, so neither is greater than the other
            assign w_both_zero = (w_a_mag == '0) && (w_b_mag == '0);

            // Sign first, then magnitude (reversed for two negatives)
            always_comb begin
                o_gt = 1'b0;
                if (w_both_zero) begin
                    o_gt = 1'b0;
                end else if (w_a_neg != w_b_neg) begin
                    o_gt = !w_a_neg;
                end else if (!w_a_neg) begin
                    o_gt = w_a_mag > w_b_mag;
                end else begin
                    o_gt = w_a_mag < w_b_mag;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Softmax sequencer: loads 4 logits with running max, launches the core, returns packed results.
// Optional watchdog on the core response is enabled by defining SOFTMAX_TIMEOUT_EN.
module softmax_seq_ctrl
    import softmax_ctrl_pkg::*;
#(
    parameter int ARITH_TYPE     = 1,
    parameter int DATA_WIDTH     = 32,
    parameter int E              = 8,
    parameter int M              = 23,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*DATA_WIDTH-1:0] out_data,
    output logic                    sm_enable,
    output logic [DATA_WIDTH-1:0]   sm_in1,
    output logic [DATA_WIDTH-1:0]   sm_in2,
    output logic [DATA_WIDTH-1:0]   sm_in3,
    output logic [DATA_WIDTH-1:0]   sm_in4,
    output logic [DATA_WIDTH-1:0]   sm_max,
    input  logic [DATA_WIDTH-1:0]   sm_out1,
    input  logic [DATA_WIDTH-1:0]   sm_out2,
    input  logic [DATA_WIDTH-1:0]   sm_out3,
    input  logic [DATA_WIDTH-1:0]   sm_out4,
    input  logic                    sm_ready,
    output logic                    busy
`ifdef SOFTMAX_TIMEOUT_EN
    ,
    output logic                    timeout_err
`endif
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   r_vec [4];
    logic [DATA_WIDTH-1:0]   r_max;
    logic [4*DATA_WIDTH-1:0] r_out;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_sm_enable;
    logic                    r_busy;
    logic                    w_accept;
    logic                    w_gt;
    logic                    w_capture;
    logic                    w_timeout;

    softmax_max_cmp #(
        .ARITH_TYPE (ARITH_TYPE),
        .DATA_WIDTH (DATA_WIDTH),
        .E          (E),
        .M          (M)
    ) u_max_cmp (
        .i_a  (in_data),
        .i_b  (r_max),
        .o_gt (w_gt)
    );

    assign w_accept  = in_valid & r_in_ready;
    assign w_capture = (r_state == ST_WAIT) & sm_ready;

`ifdef SOFTMAX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo_err;

    assign w_timeout = (r_state == ST_WAIT) && !sm_ready &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts WAIT cycles; the error flag is sticky until reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (r_state == ST_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            r_tmo_err <= r_tmo_err | w_timeout;
        end
    end

    assign timeout_err = r_tmo_err;
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-count logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_LOAD: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(3)) begin
                        w_state_nxt = ST_FIRE;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_FIRE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (sm_ready) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_timeout) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
                w_cnt_nxt   = CNT_W'(0);
            end
        endcase
    end

    // State and count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LOAD;
            r_cnt   <= CNT_W'(0);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Vector/max load, result capture and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_vec[i] <= '0;
            end
            r_max       <= '0;
            r_out       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_sm_enable <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_vec[r_cnt] <= in_data;
                // First element seeds the max; ties keep the earlier value
                if ((r_cnt == CNT_W'(0)) || w_gt) begin
                    r_max <= in_data;
                end
            end
            if (w_capture) begin
                r_out <= {sm_out4, sm_out3, sm_out2, sm_out1};
            end
            r_in_ready  <= (w_state_nxt == ST_LOAD);
            r_out_valid <= (w_state_nxt == ST_HOLD);
            r_sm_enable <= (w_state_nxt == ST_FIRE);
            r_busy      <= !((w_state_nxt == ST_LOAD) && (w_cnt_nxt == CNT_W'(0)));
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out;
    assign sm_enable = r_sm_enable;
    assign busy      = r_busy;
    assign sm_in1    = r_vec[0];
    assign sm_in2    = r_vec[1];
    assign sm_in3    = r_vec[2];
    assign sm_in4    = r_vec[3];
    assign sm_max    = r_max;

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Scoreboard bench: a fixed-point and a float instance share stimulus; the bench
// acts as upstream, downstream and the softmax core.
module tb_softmax_seq_ctrl;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          out_ready = 1'b1;
    logic          core_rdy = 1'b0;
    logic          spur_rdy = 1'b0;
    logic          core_mute = 1'b0;
    logic [DW-1:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
    logic [31:0]   rsp_idx = 32'd0;

    logic          sm_ready;
    logic [DW-1:0] so1, so2, so3, so4;
    assign sm_ready = core_rdy | spur_rdy;
    assign so1 = spur_rdy ? 32'hDEAD_0001 : c1;
    assign so2 = spur_rdy ? 32'hDEAD_0002 : c2;
    assign so3 = spur_rdy ? 32'hDEAD_0003 : c3;
    assign so4 = spur_rdy ? 32'hDEAD_0004 : c4;

    logic          fx_in_ready, fx_out_valid, fx_sm_enable, fx_busy, fx_tmo;
    logic [4*DW-1:0] fx_out_data;
    logic [DW-1:0] fx_i1, fx_i2, fx_i3, fx_i4, fx_max;
    logic          fl_in_ready, fl_out_valid, fl_sm_enable, fl_busy, fl_tmo;
    logic [4*DW-1:0] fl_out_data;
    logic [DW-1:0] fl_i1, fl_i2, fl_i3, fl_i4, fl_max;

    softmax_seq_ctrl #(.ARITH_TYPE(1), .DATA_WIDTH(DW), .E(8), .M(23), .TIMEOUT_CYCLES(16)) u_fx (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(fx_in_ready), .in_data(in_data),
        .out_valid(fx_out_valid), .out_ready(out_ready), .out_data(fx_out_data),
        .sm_enable(fx_sm_enable), .sm_in1(fx_i1), .sm_in2(fx_i2), .sm_in3(fx_i3), .sm_in4(fx_i4),
        .sm_max(fx_max), .sm_out1(so1), .sm_out2(so2), .sm_out3(so3), .sm_out4(so4),
        .sm_ready(sm_ready),
`ifdef SOFTMAX_TIMEOUT_EN
        .timeout_err(fx_tmo),
`endif
        .busy(fx_busy)
    );

    softmax_seq_ctrl #(.ARITH_TYPE(0), .DATA_WIDTH(DW), .E(8), .M(23), .TIMEOUT_CYCLES(16)) u_fl (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(fl_in_ready), .in_data(in_data),
        .out_valid(fl_out_valid), .out_ready(out_ready), .out_data(fl_out_data),
        .sm_enable(fl_sm_enable), .sm_in1(fl_i1), .sm_in2(fl_i2), .sm_in3(fl_i3), .sm_in4(fl_i4),
        .sm_max(fl_max), .sm_out1(so1), .sm_out2(so2), .sm_out3(so3), .sm_out4(so4),
        .sm_ready(sm_ready),
`ifdef SOFTMAX_TIMEOUT_EN
        .timeout_err(fl_tmo),
`endif
        .busy(fl_busy)
    );

`ifndef SOFTMAX_TIMEOUT_EN
    assign fx_tmo = 1'b0;
    assign fl_tmo = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [127:0] q_vec [$];
    logic [31:0]  q_mfx [$];
    logic [31:0]  q_mfl [$];
    logic [127:0] q_out [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Upstream beat; called right after a negedge, returns at the negedge after the handshake
    task automatic send(input logic [31:0] d);
        int g;
        g = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!fx_in_ready && g < 64) begin
            @(negedge clk);
            g++;
        end
        if (g >= 64) bound_fail("send");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [31:0] a, b, c, d, mfx, mfl, input bit gap);
        q_vec.push_back({d, c, b, a});
        q_mfx.push_back(mfx);
        q_mfl.push_back(mfl);
        send(a);
        for (int k = 1; k < 4; k++) begin
            if (gap) begin
                spur_rdy = 1'b1;
                @(negedge clk);
                spur_rdy = 1'b0;
            end
            case (k)
                1: send(b);
                2: send(c);
                default: send(d);
            endcase
        end
        chk("launch_fx", fx_sm_enable, 1'b1);
        chk("launch_fl", fl_sm_enable, 1'b1);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!fx_out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) bound_fail("wait_out");
        @(negedge clk);
    endtask

    // Core model: answers 7 cycles after each enable unless muted
    initial begin
        forever begin
            @(negedge clk);
            if (fx_sm_enable && !core_mute) begin
                repeat (7) @(negedge clk);
                c1 = 32'h0000_0011 + (rsp_idx << 8);
                c2 = 32'h0000_0022 + (rsp_idx << 8);
                c3 = 32'h0000_0033 + (rsp_idx << 8);
                c4 = 32'h0000_0044 + (rsp_idx << 8);
                q_out.push_back({c4, c3, c2, c1});
                core_rdy = 1'b1;
                @(negedge clk);
                core_rdy = 1'b0;
                rsp_idx = rsp_idx + 32'd1;
            end
        end
    end

    // Monitor: pops expectations at each launch and each result handshake
    initial begin
        logic [127:0] v;
        logic [31:0]  mx;
        logic [31:0]  ml;
        forever begin
            @(negedge clk);
            #1;
            if (fx_sm_enable || fl_sm_enable) begin
                if (q_vec.size() == 0) begin
                    bound_fail("sb_launch_underflow");
                end else begin
                    v  = q_vec.pop_front();
                    mx = q_mfx.pop_front();
                    ml = q_mfl.pop_front();
                    chk("en_fx", fx_sm_enable, 1'b1);
                    chk("en_fl", fl_sm_enable, 1'b1);
                    chk("max_fx", fx_max, mx);
                    chk("max_fl", fl_max, ml);
                    chk("vec_fx", {fx_i4, fx_i3, fx_i2, fx_i1}, v);
                    chk("vec_fl", {fl_i4, fl_i3, fl_i2, fl_i1}, v);
                end
            end
            if ((fx_out_valid || fl_out_valid) && out_ready) begin
                if (q_out.size() == 0) begin
                    bound_fail("sb_out_underflow");
                end else begin
                    v = q_out.pop_front();
                    chk("ov_fx", fx_out_valid, 1'b1);
                    chk("ov_fl", fl_out_valid, 1'b1);
                    chk("out_fx", fx_out_data, v);
                    chk("out_fl", fl_out_data, v);
                end
            end
        end
    end

    initial begin
        int n;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {fx_in_ready, fl_in_ready}, 2'b00);
        chk("rst_out_valid", {fx_out_valid, fl_out_valid}, 2'b00);
        chk("rst_busy", {fx_busy, fl_busy}, 2'b00);
        chk("rst_sm_max", {fx_max, fl_max}, 64'h0);
        chk("rst_out_data", fx_out_data, 128'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", {fx_in_ready, fl_in_ready}, 2'b11);

        // Q10.22 vector with a held result
        out_ready = 1'b0;
        send_vec(32'h0040_0000, 32'hFFC0_0000, 32'h0080_0000, 32'h0000_0000,
                 32'h0080_0000, 32'h0080_0000, 1'b0);
        n = 0;
        while (!fx_out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", n, 8);
        for (int k = 0; k < 5; k++) begin
            chk("hold_data", fx_out_data, 128'h00000044_00000033_00000022_00000011);
            chk("hold_in_ready", fx_in_ready, 1'b0);
            chk("hold_valid", fx_out_valid, 1'b1);
            chk("hold_busy", fx_busy, 1'b1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_hold", fx_in_ready, 1'b1);
        chk("valid_drop", fx_out_valid, 1'b0);

        // Negative floats, then +0 vs -0
        send_vec(32'hC000_0000, 32'hBF80_0000, 32'hC040_0000, 32'h8000_0000,
                 32'hC040_0000, 32'h8000_0000, 1'b0);
        wait_out();
        send_vec(32'h0000_0000, 32'hBF80_0000, 32'h8000_0000, 32'hC000_0000,
                 32'h0000_0000, 32'h0000_0000, 1'b0);
        wait_out();

        // Gapped input with spurious sm_ready in LOAD and FIRE
        send_vec(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F00_0000,
                 32'h4040_0000, 32'h4040_0000, 1'b1);
        spur_rdy = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0BAD_0BAD;
        @(negedge clk);
        spur_rdy = 1'b0;
        chk("no_accept_wait", fx_in_ready, 1'b0);
        chk("no_early_capture", {fx_out_valid, fl_out_valid}, 2'b00);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out();

        // Reset during WAIT abandons the vector
        core_mute = 1'b1;
        send_vec(32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003,
                 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        repeat (2) @(negedge clk);
        chk("wait_busy", fx_busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_ctrl", {fx_in_ready, fx_out_valid, fx_sm_enable, fx_busy,
                             fl_in_ready, fl_out_valid, fl_sm_enable, fl_busy}, 8'h00);
        chk("mid_rst_max", {fx_max, fl_max}, 64'h0);
        chk("mid_rst_vec", {fx_i4, fx_i3, fx_i2, fx_i1}, 128'h0);
        chk("mid_rst_out", fl_out_data, 128'h0);
        @(negedge clk);
        reset = 1'b1;
        core_mute = 1'b0;
        @(negedge clk);
        send_vec(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0005, 32'h0000_0003,
                 32'h0000_0005, 32'h0000_0005, 1'b0);
        wait_out();

`ifdef SOFTMAX_TIMEOUT_EN
        core_mute = 1'b1;
        send_vec(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004,
                 32'h0000_0004, 32'h0000_0004, 1'b0);
        repeat (16) @(negedge clk);
        chk("tmo_not_yet", {fx_tmo, fl_tmo}, 2'b00);
        chk("tmo_busy", fx_busy, 1'b1);
        @(negedge clk);
        chk("tmo_set", {fx_tmo, fl_tmo}, 2'b11);
        chk("tmo_in_ready", fx_in_ready, 1'b1);
        chk("tmo_idle", fx_busy, 1'b0);
        spur_rdy = 1'b1;
        @(negedge clk);
        spur_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_rdy_ignored", {fx_out_valid, fl_out_valid}, 2'b00);
        end
        chk("tmo_sticky", fx_tmo, 1'b1);
        core_mute = 1'b0;
`endif

        repeat (2) @(negedge clk);
        chk("sb_launch_empty", q_vec.size(), 0);
        chk("sb_out_empty", q_out.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/softmax_seq_ctrl.md
Name: softmax_seq_ctrl

Overview:
- Sequencer for the 4-input softmax datapath (fixed- or floating-point build).
- Accepts a serial stream of scalar logits, groups them into 4-element vectors and computes the running maximum during load.
- Launches the softmax core with the vector and its max, waits for completion, then returns the 4 results as one packed beat.
- Sits between the attention/score buffer (upstream) and the softmax core (downstream).

Parameters:
- ARITH_TYPE, 1: 1 = fixed-point (two's complement), 0 = IEEE-style float; selects the max-compare rule.
- DATA_WIDTH, 32: logit and result width.
- E, 8: float exponent width (used only when ARITH_TYPE=0).
- M, 23: float mantissa width (used only when ARITH_TYPE=0).
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with SOFTMAX_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream logit valid.
- in_ready  out  1  controller accepts a logit.
- in_data  in  DATA_WIDTH  logit.
- out_valid  out  1  packed result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  4*DATA_WIDTH  results; element 0 in [DATA_WIDTH-1:0].
- sm_enable  out  1  one-cycle start pulse to the core.
- sm_in1..sm_in4  out  DATA_WIDTH each  vector elements 0..3 to the core.
- sm_max  out  DATA_WIDTH  vector max to the core.
- sm_out1..sm_out4  in  DATA_WIDTH each  core results.
- sm_ready  in  1  core result valid (level).
- busy  out  1  high in any state other than LOAD with count 0.
- timeout_err  out  1  sticky error flag; exists only with SOFTMAX_TIMEOUT_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to LOAD, element count to 0.
  - Vector registers, max register, out_data, sm_in*, sm_max are cleared to 0.
  - in_ready=0 during reset; out_valid, sm_enable, busy and timeout_err are 0.
  - Reset asserted mid-operation abandons the vector; no partial result is emitted.
- State LOAD:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) writes in_data to element[count] and increments count (2-bit).
  - Max update: count 0 loads max unconditionally; later beats replace max only if the new logit is strictly greater.
  - The beat that makes count wrap from 3 to 0 moves the state to FIRE.
- State FIRE (1 cycle):
  - sm_enable=1 and in_ready=0; the state then moves to WAIT.
  - sm_in1..4 and sm_max are registered and stay stable from FIRE until leaving WAIT.
- State WAIT:
  - On the first cycle with sm_ready=1, sm_out1..4 are captured into out_data and the state moves to HOLD.
  - sm_ready is ignored in every other state.
  - The core must deassert sm_ready by the cycle after sm_enable.
- State HOLD:
  - out_valid=1 and out_data is held stable.
  - On out_ready=1 the state returns to LOAD; in_ready rises the next cycle. No bypass path.
- Throughput and latency:
  - Minimum launch latency is 1 cycle from the 4th accepted beat to sm_enable.
  - Minimum period is 4 + 1 + core latency + 1 cycles per vector.
- Fixed compare (ARITH_TYPE=1): signed DATA_WIDTH comparison.
- Float compare (ARITH_TYPE=0):
  - Operands with different sign bits: the positive one is greater.
  - Both positive: larger {exp,mant} is greater.
  - Both negative: smaller {exp,mant} is greater.
  - +0 and -0 compare equal, so the current max is kept.
  - NaN/Inf are compared as raw bit patterns; no special handling.
- Ties: the earlier element's value is retained; the max value is identical either way.

Optional Feature:
- Macro SOFTMAX_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If sm_ready has not arrived when the counter reaches TIMEOUT_CYCLES, timeout_err is set (sticky until reset), the vector is dropped and the state returns to LOAD with count 0.
  - A late sm_ready arriving after that is ignored.
- Undefined: no counter and no timeout_err port; WAIT waits indefinitely.

Decomposition:
- Package softmax_ctrl_pkg holds:
  - the state enum (LOAD, FIRE, WAIT, HOLD);
  - the element-count width constant (2);
  - the default TIMEOUT_CYCLES constant.
- Sub-module softmax_max_cmp: combinational greater-than on (a, b), parameterised by ARITH_TYPE, DATA_WIDTH, E and M.

Test Plan:
- Fixed-point, DATA_WIDTH=32, Q10.22. Stream 0x00400000, 0xFFC00000, 0x00800000, 0x00000000 (1.0, -1.0, 2.0, 0.0) -> sm_enable pulses 1 cycle after the 4th beat; sm_max=0x00800000; sm_in1..4 match the input order.
- Float build. Stream 0xC0000000, 0xBF800000, 0xC0400000, 0x80000000 (-2, -1, -3, -0) -> sm_max=0x80000000. Repeat with 0x00000000 first and 0x80000000 later -> sm_max stays 0x00000000.
- Core returns ready 7 cycles after enable with sm_out=0x11,0x22,0x33,0x44 -> out_valid next cycle; out_data=0x00000044_00000033_00000022_00000011. Hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0.
- in_valid toggling every other cycle, plus sm_ready pulsed during LOAD and FIRE -> exactly 4 beats accepted; spurious sm_ready ignored; no early capture.
- Reset (reset=0) asserted during WAIT after 4 loads -> all outputs 0 immediately. After release, a fresh 4-beat vector produces a correct max unaffected by the old data.
- With SOFTMAX_TIMEOUT_EN and TIMEOUT_CYCLES=16, core never answers -> timeout_err=1 after 16 WAIT cycles and state returns to LOAD. A later sm_ready produces no out_valid.
